uart_cmd_parser: RTL and testbench
==================================

UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 Parameter SYNC_BYTE, default 8'hA5: frame start marker.
REQ-002 Parameter N_ARGS, default 3: argument bytes per frame, legal range 1..8.
REQ-003 Parameter CMD_W, default 3: command ID width, legal range 1..8.
REQ-004 Parameter TIMEOUT_CLKS, default 1000: maximum idle clk cycles between bytes inside a frame, legal range >= 2.
REQ-005 Port clk, input, 1 bit: single clock, all logic on posedge.
REQ-006 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 Port rx_dv, input, 1 bit: one-cycle strobe, rx_byte valid.
REQ-008 Port rx_byte, input, 8 bits: received UART byte.
REQ-009 Port cmd_valid, output, 1 bit: decoded command held for the consumer.
REQ-010 Port cmd_ready, input, 1 bit: consumer accepts the command.
REQ-011 Port cmd_id, output, CMD_W bits: command byte bits [CMD_W-1:0].
REQ-012 Port cmd_args, output, N_ARGS*8 bits: first argument byte in bits [7:0].
REQ-013 Port chk_err, output, 1 bit: one-cycle pulse, checksum mismatch.
REQ-014 Port ovr_err, output, 1 bit: one-cycle pulse, good frame dropped because the output slot was occupied.
REQ-015 Port tout_err, output, 1 bit: one-cycle pulse, inter-byte timeout.

Function
REQ-016 The frame SHALL be: SYNC_BYTE, CMD byte, N_ARGS argument bytes, CHK byte, where CHK equals the XOR of CMD and all argument bytes.
REQ-017 The FSM SHALL have states IDLE, CMD, ARGS, and CHK.
- IDLE goes to CMD on rx_dv with rx_byte==SYNC_BYTE; other bytes are ignored.
- CMD goes to ARGS on rx_dv.
- ARGS goes to CHK after N_ARGS strobes.
- CHK goes to IDLE on rx_dv.
REQ-018 A SYNC_BYTE value received in the CMD, ARGS, or CHK state SHALL be treated as data.
REQ-019 The running XOR and the argument byte counter SHALL be cleared on entry to CMD.
REQ-020 On a CHK strobe with a match and a free slot, cmd_valid, cmd_id, and cmd_args SHALL load on the next edge (latency 1 clk from the CHK rx_dv cycle).
REQ-021 On a CHK strobe with a mismatch, chk_err SHALL pulse for 1 clk, the frame SHALL be discarded, and the outputs SHALL be unchanged.
REQ-022 The slot SHALL count as free when cmd_valid==0, or when cmd_valid==1 and cmd_ready==1 in the same cycle; in the second case the new frame loads and cmd_valid stays high.
REQ-023 For a good frame completing while the slot is not free, ovr_err SHALL pulse for 1 clk and the held command SHALL remain unchanged.
REQ-024 cmd_valid SHALL clear on the edge where cmd_valid&&cmd_ready, unless REQ-022 reloads it.
REQ-025 cmd_id and cmd_args SHALL be stable while cmd_valid is high and no handshake occurs.
REQ-026 If both a checksum mismatch and a non-free slot occur, only chk_err SHALL pulse.
REQ-027 An rx_dv asserted while the FSM is updating SHALL never be lost; exactly one byte is consumed per strobe.

Reset
REQ-028 On rst, the FSM SHALL go to IDLE and cmd_valid, cmd_id, cmd_args, chk_err, ovr_err, tout_err, the XOR register, and all counters SHALL be 0.
REQ-029 A reset mid-frame SHALL discard the partial frame; the first byte after reset SHALL be evaluated in IDLE.
REQ-030 rst SHALL have priority over rx_dv and cmd_ready in the same cycle.

Configuration
REQ-031 With macro UART_CMD_TIMEOUT_EN defined, a counter SHALL count clk cycles without rx_dv in any non-IDLE state.
- The counter clears on every rx_dv and on entry to IDLE.
- On reaching TIMEOUT_CLKS-1, tout_err pulses for 1 clk and the FSM goes to IDLE.
- If rx_dv coincides with the terminal count, the byte wins: no timeout occurs and the counter clears.
REQ-032 Without UART_CMD_TIMEOUT_EN, no counter SHALL exist, tout_err SHALL be tied to 0, and a partial frame SHALL wait indefinitely.

Structure
REQ-033 Package uart_cmd_pkg SHALL hold the FSM state typedef (IDLE, CMD, ARGS, CHK) and the default SYNC_BYTE constant 8'hA5.
REQ-034 No sub-module SHALL be used; the existing uart_rx instance that drives rx_dv and rx_byte SHALL be instantiated at integration level, outside this block.

Verification (defaults unless stated)
REQ-035 Good frame: bytes A5,05,11,22,33,CHK=05^11^22^33=0x05, cmd_ready=1 -> cmd_valid high for 1 clk on the cycle after CHK, cmd_id=3'd5, cmd_args=24'h332211.
REQ-036 Bad checksum: bytes A5,05,11,22,33,00 -> chk_err pulses once, cmd_valid stays 0; a following good frame decodes normally.
REQ-037 Overrun: two good frames (cmd 01 then cmd 02) with cmd_ready=0 -> cmd_id stays 1, ovr_err pulses at the second CHK; then cmd_ready=1 -> cmd_valid drops after 1 clk.
REQ-038 Simultaneous handshake: cmd_ready asserted in the exact cycle of the second frame's CHK rx_dv -> cmd_valid stays high and cmd_id updates to 2.
REQ-039 Timeout (macro defined, TIMEOUT_CLKS=16): A5,07 then 16 idle clocks -> tout_err pulses, FSM in IDLE. The same run with a byte arriving on the terminal-count cycle -> no tout_err.
REQ-040 Reset mid-frame plus sync-in-data:
- Assert rst after A5,05 -> all outputs 0; the next frame A5,01,A5,A5,A5,CHK=0x01^A5^A5^A5 decodes with cmd_args=24'hA5A5A5.
- Leading garbage bytes 00,FF before A5 -> ignored.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
`default_nettype none
// ============================================================================
// uart_cmd_pkg : shared FSM state type and default sync marker for the parser
// Revision     : 1.0
// ============================================================================
package uart_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    ARGS = 2'd2,
    CHK  = 2'd3
  } state_e;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage
`default_nettype wire

// File: rtl/uart_cmd_parser.sv
`default_nettype none
// ============================================================================
// uart_cmd_parser : SYNC/CMD/ARGS/CHK byte-frame decoder with a one-deep slot.
// Optional inter-byte timeout enabled by macro UART_CMD_TIMEOUT_EN.
// Revision        : 1.0
// ============================================================================
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT,
  parameter int         N_ARGS       = 3,
  parameter int         CMD_W        = 3,
  parameter int         TIMEOUT_CLKS = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rx_dv,
  input  logic [7:0]          rx_byte,
  output logic                cmd_valid,
  input  logic                cmd_ready,
  output logic [CMD_W-1:0]    cmd_id,
  output logic [N_ARGS*8-1:0] cmd_args,
  output logic                chk_err,
  output logic                ovr_err,
  output logic                tout_err
);

  localparam int CNT_W  = (N_ARGS > 1) ? $clog2(N_ARGS) : 1;
  localparam int ARGS_W = N_ARGS * 8;

  state_e              state_q,     state_d;
  logic [7:0]          xor_q,       xor_d;
  logic [CNT_W-1:0]    cnt_q,       cnt_d;
  logic [CMD_W-1:0]    cmd_buf_q,   cmd_buf_d;
  logic [ARGS_W-1:0]   args_buf_q,  args_buf_d;
  logic                cmd_valid_q, cmd_valid_d;
  logic [CMD_W-1:0]    cmd_id_q,    cmd_id_d;
  logic [ARGS_W-1:0]   cmd_args_q,  cmd_args_d;
  logic                chk_err_q,   chk_err_d;
  logic                ovr_err_q,   ovr_err_d;
  logic                slot_free;

`ifdef UART_CMD_TIMEOUT_EN
  localparam int TC_W = $clog2(TIMEOUT_CLKS);
  logic [TC_W-1:0] tcnt_q, tcnt_d;
  logic            tout_err_q, tout_err_d;
`endif

  // A handshake in the same cycle frees the slot for an incoming frame.
  assign slot_free = !cmd_valid_q || cmd_ready;

  always_comb begin
    state_d     = state_q;
    xor_d       = xor_q;
    cnt_d       = cnt_q;
    cmd_buf_d   = cmd_buf_q;
    args_buf_d  = args_buf_q;
    cmd_valid_d = cmd_valid_q && !cmd_ready;
    cmd_id_d    = cmd_id_q;
    cmd_args_d  = cmd_args_q;
    chk_err_d   = 1'b0;
    ovr_err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (rx_dv && rx_byte == SYNC_BYTE) begin
          state_d = CMD;
          xor_d   = 8'h00;
          cnt_d   = '0;
        end
      end
      CMD: begin
        if (rx_dv) begin
          cmd_buf_d = rx_byte[CMD_W-1:0];
          xor_d     = xor_q ^ rx_byte;
          state_d   = ARGS;
        end
      end
      ARGS: begin
        if (rx_dv) begin
          args_buf_d[8*cnt_q +: 8] = rx_byte;
          xor_d                    = xor_q ^ rx_byte;
          if (cnt_q == CNT_W'(N_ARGS - 1)) begin
            state_d = CHK;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      CHK: begin
        if (rx_dv) begin
          state_d = IDLE;
          if (rx_byte != xor_q) begin
            chk_err_d = 1'b1;
          end else if (slot_free) begin
            cmd_valid_d = 1'b1;
            cmd_id_d    = cmd_buf_q;
            cmd_args_d  = args_buf_q;
          end else begin
            ovr_err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef UART_CMD_TIMEOUT_EN
    // A byte arriving on the terminal count wins over the timeout.
    tcnt_d     = tcnt_q + 1'b1;
    tout_err_d = 1'b0;
    if (state_q == IDLE || rx_dv) begin
      tcnt_d = '0;
    end else if (tcnt_q == TC_W'(TIMEOUT_CLKS - 1)) begin
      tcnt_d     = '0;
      tout_err_d = 1'b1;
      state_d    = IDLE;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      xor_q       <= '0;
      cnt_q       <= '0;
      cmd_buf_q   <= '0;
      args_buf_q  <= '0;
      cmd_valid_q <= 1'b0;
      cmd_id_q    <= '0;
      cmd_args_q  <= '0;
      chk_err_q   <= 1'b0;
      ovr_err_q   <= 1'b0;
`ifdef UART_CMD_TIMEOUT_EN
      tcnt_q      <= '0;
      tout_err_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      xor_q       <= xor_d;
      cnt_q       <= cnt_d;
      cmd_buf_q   <= cmd_buf_d;
      args_buf_q  <= args_buf_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_id_q    <= cmd_id_d;
      cmd_args_q  <= cmd_args_d;
      chk_err_q   <= chk_err_d;
      ovr_err_q   <= ovr_err_d;
`ifdef UART_CMD_TIMEOUT_EN
      tcnt_q      <= tcnt_d;
      tout_err_q  <= tout_err_d;
`endif
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_id    = cmd_id_q;
  assign cmd_args  = cmd_args_q;
  assign chk_err   = chk_err_q;
  assign ovr_err   = ovr_err_q;
`ifdef UART_CMD_TIMEOUT_EN
  assign tout_err  = tout_err_q;
`else
  assign tout_err  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_parser.sv
`default_nettype none
// ============================================================================
// tb_uart_cmd_parser : directed self-checking bench for uart_cmd_parser
// Revision           : 1.0
// ============================================================================
module tb_uart_cmd_parser;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_dv = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        cmd_ready = 1'b0;
  logic        cmd_valid;
  logic [2:0]  cmd_id;
  logic [23:0] cmd_args;
  logic        chk_err, ovr_err, tout_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_cmd_parser #(
    .SYNC_BYTE(8'hA5), .N_ARGS(3), .CMD_W(3), .TIMEOUT_CLKS(16)
  ) dut (
    .clk(clk), .rst(rst), .rx_dv(rx_dv), .rx_byte(rx_byte),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_id(cmd_id),
    .cmd_args(cmd_args), .chk_err(chk_err), .ovr_err(ovr_err),
    .tout_err(tout_err)
  );

  // Each call consumes one clock; returns 1 time unit after the edge.
  task automatic send(input logic [7:0] b);
    rx_dv = 1'b1; rx_byte = b;
    @(posedge clk); #1;
    rx_dv = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] c, a0, a1, a2, chk);
    send(8'hA5); send(c); send(a0); send(a1); send(a2); send(chk);
  endtask

  task automatic test_reset;
    rst = 1'b1; idle(2);
    n_checks++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", cmd_valid); end
    n_checks++; if (cmd_id !== 3'd0) begin n_fail++; $display("FAIL reset_id got %h exp 0", cmd_id); end
    n_checks++; if (cmd_args !== 24'h0) begin n_fail++; $display("FAIL reset_args got %h exp 0", cmd_args); end
    n_checks++; if ({chk_err, ovr_err, tout_err} !== 3'b000) begin n_fail++; $display("FAIL reset_errs got %b exp 000", {chk_err, ovr_err, tout_err}); end
    rst = 1'b0; idle(1);
  endtask

  task automatic test_good_frame;
    cmd_ready = 1'b1;
    send_frame(8'h05, 8'h11, 8'h22, 8'h33, 8'h05);
    n_checks++; if (cmd_valid !== 1'b1) begin n_fail++; $display("FAIL good_valid got %b exp 1", cmd_valid); end
    n_checks++; if (cmd_id !== 3'd5) begin n_fail++; $display("FAIL good_id got %h exp 5", cmd_id); end
    n_checks++; if (cmd_args !== 24'h332211) begin n_fail++; $display("FAIL good_args got %h exp 332211", cmd_args); end
    idle(1);
    n_checks++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL good_valid_drop got %b exp 0", cmd_valid); end
  endtask

  task automatic test_bad_checksum;
    cmd_ready = 1'b1;
    send_frame(8'h05, 8'h11, 8'h22, 8'h33, 8'h00);
    n_checks++; if (chk_err !== 1'b1) begin n_fail++; $display("FAIL bad_chk_err got %b exp 1", chk_err); end
    n_checks++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL bad_valid got %b exp 0", cmd_valid); end
    idle(1);
    n_checks++; if (chk_err !== 1'b0) begin n_fail++; $display("FAIL bad_chk_pulse got %b exp 0", chk_err); end
    send_frame(8'h03, 8'h01, 8'h02, 8'h04, 8'h04);
    n_checks++; if ({cmd_valid, cmd_id, cmd_args} !== {1'b1, 3'd3, 24'h040201}) begin n_fail++; $display("FAIL bad_recover got %b/%h/%h exp 1/3/040201", cmd_valid, cmd_id, cmd_args); end
    idle(1);
  endtask

  task automatic test_overrun;
    cmd_ready = 1'b0;
    send_frame(8'h01, 8'h10, 8'h20, 8'h30, 8'h01);
    n_checks++; if ({cmd_valid, cmd_id} !== {1'b1, 3'd1}) begin n_fail++; $display("FAIL ovr_first got %b/%h exp 1/1", cmd_valid, cmd_id); end
    send_frame(8'h02, 8'h10, 8'h20, 8'h30, 8'h02);
    n_checks++; if (ovr_err !== 1'b1) begin n_fail++; $display("FAIL ovr_err got %b exp 1", ovr_err); end
    n_checks++; if ({cmd_valid, cmd_id, cmd_args} !== {1'b1, 3'd1, 24'h302010}) begin n_fail++; $display("FAIL ovr_held got %b/%h/%h exp 1/1/302010", cmd_valid, cmd_id, cmd_args); end
    cmd_ready = 1'b1; idle(1);
    n_checks++; if ({cmd_valid, ovr_err} !== 2'b00) begin n_fail++; $display("FAIL ovr_release got %b exp 00", {cmd_valid, ovr_err}); end
  endtask

  task automatic test_handshake;
    cmd_ready = 1'b0;
    send_frame(8'h01, 8'h10, 8'h20, 8'h30, 8'h01);
    send(8'hA5); send(8'h02); send(8'h10); send(8'h20); send(8'h30);
    cmd_ready = 1'b1;
    send(8'h02);
    n_checks++; if ({cmd_valid, cmd_id, ovr_err} !== {1'b1, 3'd2, 1'b0}) begin n_fail++; $display("FAIL hs_reload got %b/%h/%b exp 1/2/0", cmd_valid, cmd_id, ovr_err); end
    idle(1);
    n_checks++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL hs_drop got %b exp 0", cmd_valid); end
  endtask

  task automatic test_reset_mid_frame;
    cmd_ready = 1'b1;
    send(8'hA5); send(8'h05);
    rst = 1'b1; rx_dv = 1'b1; rx_byte = 8'hA5;
    @(posedge clk); #1;
    rx_dv = 1'b0; rst = 1'b0;
    n_checks++; if ({cmd_valid, cmd_id, cmd_args, chk_err, ovr_err, tout_err} !== 30'h0) begin n_fail++; $display("FAIL rst_mid_outs got %b/%h/%h exp all 0", cmd_valid, cmd_id, cmd_args); end
    send(8'h00); send(8'hFF);
    send_frame(8'h01, 8'hA5, 8'hA5, 8'hA5, 8'hA4);
    n_checks++; if ({cmd_valid, cmd_id, cmd_args, chk_err} !== {1'b1, 3'd1, 24'hA5A5A5, 1'b0}) begin n_fail++; $display("FAIL rst_sync_data got %b/%h/%h exp 1/1/a5a5a5", cmd_valid, cmd_id, cmd_args); end
    idle(1);
  endtask

  task automatic test_back_to_back;
    cmd_ready = 1'b1;
    send_frame(8'h06, 8'h01, 8'h02, 8'h03, 8'h06);
    n_checks++; if ({cmd_valid, cmd_id, cmd_args} !== {1'b1, 3'd6, 24'h030201}) begin n_fail++; $display("FAIL b2b_first got %b/%h/%h exp 1/6/030201", cmd_valid, cmd_id, cmd_args); end
    send_frame(8'h04, 8'hF0, 8'h0F, 8'h55, 8'hAE);
    n_checks++; if ({cmd_valid, cmd_id, cmd_args} !== {1'b1, 3'd4, 24'h550FF0}) begin n_fail++; $display("FAIL b2b_second got %b/%h/%h exp 1/4/550ff0", cmd_valid, cmd_id, cmd_args); end
    idle(1);
  endtask

  task automatic test_timeout;
    cmd_ready = 1'b1;
`ifdef UART_CMD_TIMEOUT_EN
    send(8'hA5); send(8'h07);
    idle(15);
    n_checks++; if (tout_err !== 1'b0) begin n_fail++; $display("FAIL tout_early got %b exp 0", tout_err); end
    idle(1);
    n_checks++; if (tout_err !== 1'b1) begin n_fail++; $display("FAIL tout_pulse got %b exp 1", tout_err); end
    send_frame(8'h02, 8'h10, 8'h20, 8'h30, 8'h02);
    n_checks++; if ({cmd_valid, cmd_id, tout_err} !== {1'b1, 3'd2, 1'b0}) begin n_fail++; $display("FAIL tout_idle got %b/%h/%b exp 1/2/0", cmd_valid, cmd_id, tout_err); end
    idle(1);
    send(8'hA5); send(8'h07);
    idle(15);
    send(8'h11);
    n_checks++; if (tout_err !== 1'b0) begin n_fail++; $display("FAIL tout_byte_wins got %b exp 0", tout_err); end
    send(8'h22); send(8'h33); send(8'h07);
`else
    send(8'hA5); send(8'h07);
    idle(40);
    n_checks++; if (tout_err !== 1'b0) begin n_fail++; $display("FAIL tout_tied got %b exp 0", tout_err); end
    send(8'h11); send(8'h22); send(8'h33); send(8'h07);
`endif
    n_checks++; if ({cmd_valid, cmd_id, cmd_args} !== {1'b1, 3'd7, 24'h332211}) begin n_fail++; $display("FAIL tout_late_frame got %b/%h/%h exp 1/7/332211", cmd_valid, cmd_id, cmd_args); end
    idle(1);
  endtask

  initial begin
    #1;
    test_reset;
    test_good_frame;
    test_bad_checksum;
    test_overrun;
    test_handshake;
    test_reset_mid_frame;
    test_back_to_back;
    test_timeout;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
